approx_err_acc: RTL and testbench

- Downstream consumer of an 8x8 approximate multiplier's 16-bit product (operands a, b; product prod8).
- Computes the exact product internally and the error distance ED = |exact - prod8| per sample.
- Accumulates error statistics over a programmed number of samples for error-rate / MED characterisation.
- Sits between the multiplier under test and the characterisation readout logic.

---
 rtl/approx_err_pkg.sv | 22 ++
 rtl/err_calc_stage.sv | 75 +++++++
 rtl/approx_err_acc.sv | 164 ++++++++++++++++
 tb/tb_approx_err_acc.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_err_pkg.sv
// Shared state encoding, operand widths and helpers for the approximate-multiplier
// error accumulator (approx_err_acc and its err_calc_stage pipeline).
package approx_err_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int DRAIN_CYC = 2;

  // Unsigned error distance between the exact and the approximate product.
  function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] x,
                                                 input logic [PROD_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/err_calc_stage.sv
// Two-stage pipeline: S1 captures an accepted sample, S2 holds its error distance
// and non-zero flag. APPROX_ERR_MAX_EN also forwards the operands alongside.
module err_calc_stage
  import approx_err_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] prod8,
  output logic              out_valid,
  output logic [PROD_W-1:0] ed,
  output logic              nz
`ifdef APPROX_ERR_MAX_EN
  ,
  output logic [OP_W-1:0]   out_a,
  output logic [OP_W-1:0]   out_b
`endif
);

  logic              s1_valid;
  logic [OP_W-1:0]   s1_a;
  logic [OP_W-1:0]   s1_b;
  logic [PROD_W-1:0] s1_prod;
  logic [PROD_W-1:0] exact;
  logic [PROD_W-1:0] s1_ed;

  // S1 data only loads on accept so idle cycles do not disturb the registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_prod <= prod8;
      end
    end
  end

  assign exact = PROD_W'(s1_a) * PROD_W'(s1_b);
  assign s1_ed = abs_diff(exact, s1_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ed        <= '0;
      nz        <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ed <= s1_ed;
        nz <= (s1_ed != '0);
      end
    end
  end

`ifdef APPROX_ERR_MAX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a <= '0;
      out_b <= '0;
    end else if (s1_valid) begin
      out_a <= s1_a;
      out_b <= s1_b;
    end
  end
`endif

endmodule

// File: rtl/approx_err_acc.sv
// Error-statistics accumulator for an 8x8 approximate multiplier: run FSM, sample
// and error counters, saturating ED sum. Define APPROX_ERR_MAX_EN for max-ED tracking.
module approx_err_acc
  import approx_err_pkg::*;
#(
  parameter int CNT_W = 17,
  parameter int SUM_W = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] prod8,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  sum_ed
`ifdef APPROX_ERR_MAX_EN
  ,
  output logic [PROD_W-1:0] max_ed,
  output logic [OP_W-1:0]   max_a,
  output logic [OP_W-1:0]   max_b
`endif
);

  state_t            state;
  state_t            next_state;
  logic [1:0]        drain_cnt;
  logic [1:0]        next_drain;
  logic [CNT_W-1:0]  target;
  logic              accept;
  logic              start_go;
  logic              last_accept;
  logic              s2_valid;
  logic              s2_nz;
  logic [PROD_W-1:0] s2_ed;
  logic [SUM_W:0]    sum_wide;
  logic [SUM_W-1:0]  sum_sat;
`ifdef APPROX_ERR_MAX_EN
  logic [OP_W-1:0]   s2_a;
  logic [OP_W-1:0]   s2_b;
`endif

  assign accept      = in_valid && in_ready;
  assign start_go    = (state == IDLE) && start;
  assign last_accept = (sample_cnt + CNT_W'(1)) == target;

  err_calc_stage u_calc (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .a         (a),
    .b         (b),
    .prod8     (prod8),
    .out_valid (s2_valid),
    .ed        (s2_ed),
    .nz        (s2_nz)
`ifdef APPROX_ERR_MAX_EN
    ,
    .out_a     (s2_a),
    .out_b     (s2_b)
`endif
  );

  // The final accept leaves RUN on the same edge so nothing more is taken in;
  // DRAIN then waits out the two pipeline stages before announcing done.
  always_comb begin
    next_state = state;
    next_drain = drain_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && last_accept) begin
          next_state = DRAIN;
          next_drain = 2'(DRAIN_CYC - 1);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          next_state = DONE;
        end else begin
          next_drain = drain_cnt - 2'd1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_drain;
      in_ready  <= (next_state == RUN);
      busy      <= (next_state == RUN) || (next_state == DRAIN);
      done      <= (next_state == DONE);
    end
  end

  // One spare bit catches the carry so the sum clamps instead of wrapping.
  assign sum_wide = {1'b0, sum_ed} + (SUM_W + 1)'(s2_ed);
  assign sum_sat  = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target     <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
    end else if (start_go) begin
      target     <= num_samples;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
    end else begin
      if (accept) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
      if (s2_valid) begin
        err_cnt <= err_cnt + CNT_W'(s2_nz);
        sum_ed  <= sum_sat;
      end
    end
  end

`ifdef APPROX_ERR_MAX_EN
  // Strict greater-than keeps the first sample that reached the maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_ed <= '0;
      max_a  <= '0;
      max_b  <= '0;
    end else if (start_go) begin
      max_ed <= '0;
      max_a  <= '0;
      max_b  <= '0;
    end else if (s2_valid && (s2_ed > max_ed)) begin
      max_ed <= s2_ed;
      max_a  <= s2_a;
      max_b  <= s2_b;
    end
  end
`endif

endmodule

// File: tb/tb_approx_err_acc.sv
// Directed self-checking bench for approx_err_acc; a second instance with a
// 17-bit sum exercises saturation. Define APPROX_ERR_MAX_EN to check max tracking.
`timescale 1ns/1ps
module tb_approx_err_acc;

  localparam int CNT_W = 17;
  localparam int SUM_W = 33;
  localparam int SAT_W = 17;

  typedef struct {
    longint cnt;
    longint err;
    longint sum;
    longint sat_sum;
    longint max_ed;
    longint max_a;
    longint max_b;
  } run_exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [15:0]      prod8;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [SUM_W-1:0] sum_ed;
  logic             sat_in_ready;
  logic             sat_busy;
  logic             sat_done;
  logic [CNT_W-1:0] sat_sample_cnt;
  logic [CNT_W-1:0] sat_err_cnt;
  logic [SAT_W-1:0] sat_sum_ed;
`ifdef APPROX_ERR_MAX_EN
  logic [15:0]      max_ed;
  logic [7:0]       max_a;
  logic [7:0]       max_b;
  logic [15:0]      sat_max_ed;
  logic [7:0]       sat_max_a;
  logic [7:0]       sat_max_b;
`endif

  int       checks = 0;
  int       passes = 0;
  int       fails  = 0;
  run_exp_t model;
  run_exp_t exp_q[$];

  approx_err_acc #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .prod8       (prod8),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .sum_ed      (sum_ed)
`ifdef APPROX_ERR_MAX_EN
    ,
    .max_ed      (max_ed),
    .max_a       (max_a),
    .max_b       (max_b)
`endif
  );

  approx_err_acc #(.CNT_W(CNT_W), .SUM_W(SAT_W)) u_sat (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (sat_in_ready),
    .a           (a),
    .b           (b),
    .prod8       (prod8),
    .busy        (sat_busy),
    .done        (sat_done),
    .sample_cnt  (sat_sample_cnt),
    .err_cnt     (sat_err_cnt),
    .sum_ed      (sat_sum_ed)
`ifdef APPROX_ERR_MAX_EN
    ,
    .max_ed      (sat_max_ed),
    .max_a       (sat_max_a),
    .max_b       (sat_max_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    model = '{0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic modelSample(input logic [7:0] ma, input logic [7:0] mb, input logic [15:0] mp);
    longint exact;
    longint ed;
    exact = longint'(ma) * longint'(mb);
    ed    = (exact > longint'(mp)) ? exact - longint'(mp) : longint'(mp) - exact;
    model.cnt++;
    if (ed != 0) model.err++;
    model.sum += ed;
    if (ed > model.max_ed) begin
      model.max_ed = ed;
      model.max_a  = longint'(ma);
      model.max_b  = longint'(mb);
    end
  endtask

  task automatic pushRun();
    run_exp_t e;
    e         = model;
    e.sum     = (model.sum > 64'h1_FFFF_FFFF) ? 64'h1_FFFF_FFFF : model.sum;
    e.sat_sum = (model.sum > 131071) ? 131071 : model.sum;
    exp_q.push_back(e);
  endtask

  task automatic checkRun(input string tag);
    run_exp_t e;
    checkOutput({tag, "_queue_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput({tag, "_sample_cnt"}, 64'(sample_cnt), e.cnt);
      checkOutput({tag, "_err_cnt"}, 64'(err_cnt), e.err);
      checkOutput({tag, "_sum_ed"}, 64'(sum_ed), e.sum);
      checkOutput({tag, "_sat_sum_ed"}, 64'(sat_sum_ed), e.sat_sum);
`ifdef APPROX_ERR_MAX_EN
      checkOutput({tag, "_max_ed"}, 64'(max_ed), e.max_ed);
      checkOutput({tag, "_max_a"}, 64'(max_a), e.max_a);
      checkOutput({tag, "_max_b"}, 64'(max_b), e.max_b);
`endif
    end
  endtask

  task automatic startRun(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    @(negedge clk);
    start       = 1'b0;
    modelClear();
  endtask

  // Presents one sample and holds it until the posedge that accepts it.
  task automatic applyStimulus(input logic [7:0] sa, input logic [7:0] sb, input logic [15:0] sp);
    int guard = 0;
    in_valid = 1'b1;
    a        = sa;
    b        = sb;
    prod8    = sp;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    modelSample(sa, sb, sp);
  endtask

  task automatic waitDone(input string tag);
    int guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_done_seen"}, 64'(done), 64'd1);
    checkRun(tag);
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    prod8       = '0;
    modelClear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("rst_sum_ed", 64'(sum_ed), 64'd0);

    $display("[TB] basic run, exact products");
    startRun(4);
    checkOutput("basic_busy", 64'(busy), 64'd1);
    applyStimulus(8'd3, 8'd5, 16'd15);
    applyStimulus(8'd255, 8'd255, 16'd65025);
    applyStimulus(8'd0, 8'd9, 16'd0);
    applyStimulus(8'd16, 8'd16, 16'd256);
    pushRun();
    waitDone("basic");

    $display("[TB] errors in both directions");
    startRun(3);
    applyStimulus(8'd3, 8'd5, 16'd14);
    applyStimulus(8'd3, 8'd5, 16'd17);
    applyStimulus(8'd200, 8'd100, 16'd0);
    pushRun();
    waitDone("errs");

    $display("[TB] handshake gaps and latency");
    startRun(2);
    in_valid = 1'b1; a = 8'd2; b = 8'd2; prod8 = 16'd7;
    modelSample(8'd2, 8'd2, 16'd7);
    @(negedge clk);
    checkOutput("hs_cnt_after_first", 64'(sample_cnt), 64'd1);
    checkOutput("hs_ready_after_first", 64'(in_ready), 64'd1);
    checkOutput("hs_sum_e0", 64'(sum_ed), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("hs_sum_e1", 64'(sum_ed), 64'd0);
    checkOutput("hs_cnt_gap", 64'(sample_cnt), 64'd1);
    @(negedge clk);
    checkOutput("hs_sum_e2", 64'(sum_ed), 64'd3);
    in_valid = 1'b1; a = 8'd3; b = 8'd5; prod8 = 16'd14;
    modelSample(8'd3, 8'd5, 16'd14);
    pushRun();
    @(negedge clk);
    checkOutput("hs_cnt_final", 64'(sample_cnt), 64'd2);
    checkOutput("hs_ready_drop", 64'(in_ready), 64'd0);
    checkOutput("hs_busy_drain", 64'(busy), 64'd1);
    checkOutput("hs_done_e0", 64'(done), 64'd0);
    @(negedge clk);
    checkOutput("hs_done_e1", 64'(done), 64'd0);
    checkOutput("hs_sum_last_e1", 64'(sum_ed), 64'd3);
    @(negedge clk);
    checkOutput("hs_done_e2", 64'(done), 64'd1);
    checkRun("hs");
    @(negedge clk);
    checkOutput("hs_done_gone", 64'(done), 64'd0);
    checkOutput("hs_cnt_held", 64'(sample_cnt), 64'd2);
    in_valid = 1'b0;

    $display("[TB] zero target");
    startRun(0);
    modelClear();
    pushRun();
    waitDone("zero");

    $display("[TB] start ignored during run");
    startRun(3);
    applyStimulus(8'd3, 8'd5, 16'd14);
    start       = 1'b1;
    num_samples = CNT_W'(1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("mask_cnt_kept", 64'(sample_cnt), 64'd1);
    checkOutput("mask_busy", 64'(busy), 64'd1);
    applyStimulus(8'd10, 8'd10, 16'd100);
    applyStimulus(8'd7, 8'd7, 16'd50);
    pushRun();
    waitDone("mask");

    $display("[TB] saturation");
    startRun(4);
    for (int i = 0; i < 4; i++) applyStimulus(8'd0, 8'd0, 16'hFFFF);
    pushRun();
    waitDone("sat");

    $display("[TB] reset mid-run");
    startRun(10);
    for (int i = 0; i < 5; i++) applyStimulus(8'd9, 8'd9, 16'd80);
    checkOutput("mid_sum_before", 64'(sum_ed), 64'd3);
    rst = 1'b1;
    #1;
    checkOutput("mid_sample_cnt", 64'(sample_cnt), 64'd0);
    checkOutput("mid_err_cnt", 64'(err_cnt), 64'd0);
    checkOutput("mid_sum_ed", 64'(sum_ed), 64'd0);
    checkOutput("mid_busy", 64'(busy), 64'd0);
    checkOutput("mid_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelClear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("mid_no_done", 64'(done), 64'd0);
    end
    startRun(2);
    applyStimulus(8'd12, 8'd12, 16'd150);
    applyStimulus(8'd255, 8'd1, 16'd255);
    pushRun();
    waitDone("after_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
